// File: rtl/imem_loader.sv
// Instruction memory loader: packs a byte stream little-endian into words,
// writes them to consecutive addresses and holds the core in reset until the
// programme image has been written.
module imem_loader #(
    parameter int unsigned AWIDTH = 8,
    parameter int unsigned DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [AWIDTH:0]   num_words,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [AWIDTH-1:0] mem_waddr,
    output logic [DWIDTH-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              cpu_hold
);

    localparam int unsigned BPW  = DWIDTH / 8;
    localparam int unsigned BCW  = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int unsigned LENW = AWIDTH + 1;
    localparam logic [LENW-1:0] CAP = LENW'(1) << AWIDTH;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [LENW-1:0]     len_q, len_d;
    logic [AWIDTH-1:0]   word_cnt_q, word_cnt_d;
    logic [BCW-1:0]      byte_cnt_q, byte_cnt_d;
    logic [DWIDTH-1:0]   word_q, word_d;
    logic [AWIDTH-1:0]   waddr_q, waddr_d;
    logic [DWIDTH-1:0]   wdata_q, wdata_d;
    logic                byte_ready_q, byte_ready_d;
    logic                mem_we_q, mem_we_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                cpu_hold_q, cpu_hold_d;
    logic                xfer_c;

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            word_cnt_q   <= '0;
            byte_cnt_q   <= '0;
            word_q       <= '0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            byte_ready_q <= 1'b0;
            mem_we_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cpu_hold_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            word_cnt_q   <= word_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            word_q       <= word_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            byte_ready_q <= byte_ready_d;
            mem_we_q     <= mem_we_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            cpu_hold_q   <= cpu_hold_d;
        end
    end

    // Next-state, byte packing and output decode from the upcoming state
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        xfer_c     = byte_valid && byte_ready_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    len_d      = (num_words > CAP) ? CAP : num_words;
                    word_cnt_d = '0;
                    byte_cnt_d = '0;
                    state_d    = (len_d == '0) ? S_DONE : S_RECV;
                end
            end
            S_RECV: begin
                if (xfer_c) begin
                    for (int i = 0; i < int'(BPW); i++) begin
                        if (byte_cnt_q == BCW'(i)) begin
                            word_d[8*i +: 8] = byte_data;
                        end
                    end
                    if (byte_cnt_q == BCW'(BPW - 1)) begin
                        byte_cnt_d = '0;
                        waddr_d    = word_cnt_q;
                        wdata_d    = word_d;
                        state_d    = S_WRITE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + BCW'(1);
                    end
                end
            end
            S_WRITE: begin
                if (LENW'(word_cnt_q) == (len_q - LENW'(1))) begin
                    state_d = S_DONE;
                end else begin
                    word_cnt_d = word_cnt_q + AWIDTH'(1);
                    state_d    = S_RECV;
                end
            end
            default: state_d = S_IDLE;
        endcase

        byte_ready_d = (state_d == S_RECV);
        mem_we_d     = (state_d == S_WRITE);
        busy_d       = (state_d == S_RECV) || (state_d == S_WRITE);
        done_d       = (state_d == S_DONE);
        cpu_hold_d   = (state_d != S_DONE);
    end

    assign byte_ready = byte_ready_q;
    assign mem_we     = mem_we_q;
    assign mem_waddr  = waddr_q;
    assign mem_wdata  = wdata_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign cpu_hold   = cpu_hold_q;

endmodule
